// File: rtl/snoop_bus_ctrl.sv
// snoop_bus_ctrl: two-core snooping bus controller.
// Arbitrates one owner at a time. The owner's op is run through SNOOP and then
// XFER (cache-to-cache), MEM (unified memory) or straight to DONE.
// Optional feature: define SNOOP_BUS_TIMEOUT_EN to bound the MEM wait with an
// 8-bit counter that raises bus_err and aborts to DONE.
//
// Handshake: request bits are level signals. A core holds them until its
// transaction finishes, which is marked by grant dropping in the IDLE cycle
// after DONE. Requests are only sampled in IDLE. grant is the acknowledgement.
// u_rdy is the memory's ready signal and is only looked at in MEM.
module snoop_bus_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  read_miss,
  input  logic [1:0]  write_miss,
  input  logic [1:0]  invalidate,
  input  logic [1:0]  mem_req,
  input  logic [12:0] addr0,
  input  logic [12:0] addr1,
  input  logic [1:0]  found,
  input  logic [15:0] snoop_data0,
  input  logic [15:0] snoop_data1,
  input  logic        u_rdy,
  output logic [1:0]  grant,
  output logic [1:0]  cpu_search,
  output logic [10:0] BOCI,
  output logic [15:0] other_proc_data,
  output logic [1:0]  cpu_datasel0,
  output logic [1:0]  cpu_datasel1,
  output logic [1:0]  cpu_dmem_permission,
  output logic        bus_err,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARB   = 3'd1,
    S_SNOOP = 3'd2,
    S_XFER  = 3'd3,
    S_MEM   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    OP_RM  = 2'd0,
    OP_WM  = 2'd1,
    OP_INV = 2'd2,
    OP_MEM = 2'd3
  } op_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_ptr;
  logic        r_owner;
  op_t         r_op;
  logic [10:0] r_boci;
  logic [15:0] r_sdata;

  logic [1:0]  w_req;
  logic        w_arb_owner;
  op_t         w_arb_op;
  logic [12:0] w_arb_addr;
  logic        w_other;
  logic        w_oth_found;
  logic [15:0] w_oth_data;
  logic [1:0]  w_own_oh;
  logic [1:0]  w_oth_oh;
  logic [1:0]  w_own_dsel;
  logic        w_tmo;
  logic        w_unused_addr_lsbs;

  // Word-offset bits of the addresses do not take part in the line index.
  assign w_unused_addr_lsbs = ^{addr0[1:0], addr1[1:0]};

  assign w_req    = read_miss | write_miss | invalidate | mem_req;
  assign w_other  = ~r_owner;
  assign w_own_oh = r_owner ? 2'b10 : 2'b01;
  assign w_oth_oh = ~w_own_oh;
  assign dbg_state = r_state;

  // The non-owner answers the snoop; its response is what gets forwarded.
  assign w_oth_found = found[w_other];
  assign w_oth_data  = r_owner ? snoop_data0 : snoop_data1;

  // Arbitration and op decode on the IDLE requests.
  always_comb begin
    w_arb_owner = r_ptr;
    if (w_req == 2'b01) begin
      w_arb_owner = 1'b0;
    end else if (w_req == 2'b10) begin
      w_arb_owner = 1'b1;
    end
    w_arb_op = OP_MEM;
    if (invalidate[w_arb_owner]) begin
      w_arb_op = OP_INV;
    end else if (write_miss[w_arb_owner]) begin
      w_arb_op = OP_WM;
    end else if (read_miss[w_arb_owner]) begin
      w_arb_op = OP_RM;
    end
    w_arb_addr = w_arb_owner ? addr1 : addr0;
  end

`ifdef SNOOP_BUS_TIMEOUT_EN
  logic [7:0] r_cnt;

  // The timeout fires once the counter has reached 255 while still in MEM.
  assign w_tmo = (r_state == S_MEM) && (r_cnt == 8'hFF);

  // MEM wait counter: cleared on MEM entry, counts cycles without u_rdy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 8'd0;
    end else if ((r_state != S_MEM) && (w_next == S_MEM)) begin
      r_cnt <= 8'd0;
    end else if ((r_state == S_MEM) && !u_rdy && !w_tmo) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end
`else
  assign w_tmo = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Transaction context: the owner, op and line index are captured on the
  // edge into ARB so that grant and BOCI are already valid during ARB.
  // The snoop word is captured on the edge that leaves SNOOP.
  // The pointer moves to the non-owner as DONE completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= 1'b0;
      r_owner <= 1'b0;
      r_op    <= OP_RM;
      r_boci  <= 11'd0;
      r_sdata <= 16'd0;
    end else begin
      if ((r_state == S_IDLE) && (w_req != 2'b00)) begin
        r_owner <= w_arb_owner;
        r_op    <= w_arb_op;
        r_boci  <= w_arb_addr[12:2];
      end
      if (r_state == S_SNOOP) begin
        r_sdata <= w_oth_data;
      end
      if (r_state == S_DONE) begin
        r_ptr <= w_other;
      end
    end
  end

  // Next-state logic. The hit/miss decision uses the same found value that
  // is current on the edge leaving SNOOP.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req != 2'b00) begin
          w_next = S_ARB;
        end
      end
      S_ARB: begin
        w_next = (r_op == OP_MEM) ? S_MEM : S_SNOOP;
      end
      S_SNOOP: begin
        if (r_op == OP_INV) begin
          w_next = S_DONE;
        end else if (w_oth_found) begin
          w_next = S_XFER;
        end else begin
          w_next = S_MEM;
        end
      end
      S_XFER: begin
        w_next = S_DONE;
      end
      S_MEM: begin
        if (w_tmo || u_rdy) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the state and the captured context.
  always_comb begin
    grant               = 2'b00;
    cpu_search          = 2'b00;
    BOCI                = 11'd0;
    other_proc_data     = 16'd0;
    cpu_dmem_permission = 2'b00;
    bus_err             = 1'b0;
    w_own_dsel          = 2'b11;
    if (r_state != S_IDLE) begin
      grant = w_own_oh;
      BOCI  = r_boci;
    end
    case (r_state)
      S_SNOOP: begin
        cpu_search = w_oth_oh;
      end
      S_XFER: begin
        other_proc_data = r_sdata;
        w_own_dsel      = 2'b01;
      end
      S_MEM: begin
        cpu_dmem_permission = w_own_oh;
        w_own_dsel          = 2'b00;
        bus_err             = w_tmo;
      end
      default: begin
      end
    endcase
    cpu_datasel0 = r_owner ? 2'b11 : w_own_dsel;
    cpu_datasel1 = r_owner ? w_own_dsel : 2'b11;
  end

endmodule
